// File: rtl/preload_streamer_pkg.sv
// Shared types and default sizing for the preprocess-load transmit path.
package preload_streamer_pkg;

    localparam int NUM_ENGINE  = 4;
    localparam int LIT_IDX_MAX = 16;
    localparam int MAX_CLA     = 256;
    localparam int ADDR_W      = 16;
    localparam int NODE_W      = 32;
    localparam int DUMMY_W     = 16;

    typedef logic [NODE_W-1:0]  node_t;
    typedef logic [DUMMY_W-1:0] dummy_entry_t;

    typedef struct packed {
        logic is_clause;
        logic first_of_engine;
    } beat_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLA  = 2'd1,
        ST_PTR  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/preload_streamer_if.sv
// Source-memory read port plus loader beat outputs of the preload streamer.
interface preload_streamer_if
    import preload_streamer_pkg::*;
#(
    parameter int ADDR_W = preload_streamer_pkg::ADDR_W
) ();

    logic              src_rd_en;
    logic [ADDR_W-1:0] src_rd_addr;
    node_t             src_rd_data;
    node_t             clause_out;
    dummy_entry_t      ptr_out;
    logic              load_clause_out;
    logic              load_ptr_out;
    logic              load_change_engine_out;

    modport master (
        output src_rd_en, src_rd_addr, clause_out, ptr_out,
               load_clause_out, load_ptr_out, load_change_engine_out,
        input  src_rd_data
    );

    modport slave (
        input  src_rd_en, src_rd_addr, clause_out, ptr_out,
               load_clause_out, load_ptr_out, load_change_engine_out,
        output src_rd_data
    );

endinterface

// File: rtl/preload_streamer_read_tag_pipe.sv
// Delay line carrying read-valid and beat tag alongside the source memory latency.
module preload_streamer_read_tag_pipe
    import preload_streamer_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      in_valid,
    input  beat_tag_t in_tag,
    output logic      out_valid,
    output beat_tag_t out_tag
);

    logic      valid_r [STAGES];
    beat_tag_t tag_r   [STAGES];

    // Shift tag/valid one stage per cycle; reset drops any in-flight read.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_r[i] <= 1'b0;
                tag_r[i]   <= '0;
            end
        end else begin
            valid_r[0] <= in_valid;
            tag_r[0]   <= in_tag;
            for (int i = 1; i < STAGES; i++) begin
                valid_r[i] <= valid_r[i-1];
                tag_r[i]   <= tag_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign out_tag   = tag_r[STAGES-1];

endmodule

// File: rtl/preload_streamer.sv
// Streams a preprocessed image from source memory as per-engine clause beats
// followed by pointer beats, with a change-engine strobe on each engine's first beat.
module preload_streamer
    import preload_streamer_pkg::*;
#(
    parameter int NUM_ENGINE  = preload_streamer_pkg::NUM_ENGINE,
    parameter int LIT_IDX_MAX = preload_streamer_pkg::LIT_IDX_MAX,
    parameter int MAX_CLA     = preload_streamer_pkg::MAX_CLA,
    parameter int ADDR_W      = preload_streamer_pkg::ADDR_W,
    localparam int CW         = $clog2(MAX_CLA + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pause,
    input  logic [NUM_ENGINE*CW-1:0] cla_count_in,
    preload_streamer_if.master       bus,
    output logic                     busy,
    output logic                     done
);

    localparam int PTR_BEATS = 2 * LIT_IDX_MAX;
    localparam int PW        = $clog2(PTR_BEATS) + 1;
    localparam int EW        = NUM_ENGINE;

    state_t            state_r, state_s;
    logic [CW-1:0]     cla_count_r [NUM_ENGINE];
    logic [EW-1:0]     engine_r;
    logic [CW-1:0]     cla_cnt_r;
    logic [PW-1:0]     ptr_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              first_r;
    logic              busy_r;
    logic              done_r;

    logic              issue_s;
    logic              last_cla_s;
    logic              last_ptr_s;
    logic              last_engine_s;
    logic [CW-1:0]     cur_count_s;
    logic [CW-1:0]     next_count_s;
    beat_tag_t         issue_tag_s;
    logic              ret_valid_s;
    beat_tag_t         ret_tag_s;

    // Read-issue qualifiers and count selection for the current/next engine.
    always_comb begin
        cur_count_s  = '0;
        next_count_s = '0;
        for (int e = 0; e < NUM_ENGINE; e++) begin
            if (engine_r == EW'(e)) begin
                cur_count_s = cla_count_r[e];
            end else begin
                cur_count_s = cur_count_s;
            end
            if ((engine_r + EW'(1)) == EW'(e)) begin
                next_count_s = cla_count_r[e];
            end else begin
                next_count_s = next_count_s;
            end
        end
        issue_s       = ((state_r == ST_CLA) || (state_r == ST_PTR)) && !pause;
        last_cla_s    = (cla_cnt_r + CW'(1)) == cur_count_s;
        last_ptr_s    = (ptr_cnt_r + PW'(1)) == PW'(PTR_BEATS);
        last_engine_s = engine_r == EW'(NUM_ENGINE - 1);
        issue_tag_s.is_clause       = (state_r == ST_CLA);
        issue_tag_s.first_of_engine = first_r;
    end

    // Next-state logic; engines with zero clauses go straight to pointer beats.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (cla_count_in[CW-1:0] == CW'(0)) ? ST_PTR : ST_CLA;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLA: begin
                if (issue_s && last_cla_s) begin
                    state_s = ST_PTR;
                end else begin
                    state_s = ST_CLA;
                end
            end
            ST_PTR: begin
                if (issue_s && last_ptr_s) begin
                    if (last_engine_s) begin
                        state_s = ST_DONE;
                    end else if (next_count_s == CW'(0)) begin
                        state_s = ST_PTR;
                    end else begin
                        state_s = ST_CLA;
                    end
                end else begin
                    state_s = ST_PTR;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, latched counts, read counters and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            engine_r  <= '0;
            cla_cnt_r <= '0;
            ptr_cnt_r <= '0;
            addr_r    <= '0;
            first_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            for (int e = 0; e < NUM_ENGINE; e++) begin
                cla_count_r[e] <= '0;
            end
        end else begin
            state_r <= state_s;
            // The final beat returns while in DONE, so done lands one cycle after it.
            done_r  <= (state_r == ST_DONE);
            if ((state_r == ST_IDLE) && start) begin
                for (int e = 0; e < NUM_ENGINE; e++) begin
                    cla_count_r[e] <= cla_count_in[e*CW +: CW];
                end
                engine_r  <= '0;
                cla_cnt_r <= '0;
                ptr_cnt_r <= '0;
                addr_r    <= '0;
                first_r   <= 1'b1;
                busy_r    <= 1'b1;
            end else if (state_r == ST_DONE) begin
                busy_r <= 1'b0;
            end else if (issue_s) begin
                addr_r  <= addr_r + ADDR_W'(1);
                first_r <= 1'b0;
                if (state_r == ST_CLA) begin
                    cla_cnt_r <= last_cla_s ? CW'(0) : (cla_cnt_r + CW'(1));
                end else if (last_ptr_s) begin
                    ptr_cnt_r <= '0;
                    if (!last_engine_s) begin
                        engine_r <= engine_r + EW'(1);
                        first_r  <= 1'b1;
                    end
                end else begin
                    ptr_cnt_r <= ptr_cnt_r + PW'(1);
                end
            end
        end
    end

    preload_streamer_read_tag_pipe #(.STAGES(1)) u_tag_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (issue_s),
        .in_tag    (issue_tag_s),
        .out_valid (ret_valid_s),
        .out_tag   (ret_tag_s)
    );

    // Beat outputs follow the returning memory word directly to keep 2-cycle latency.
    always_comb begin
        bus.src_rd_en              = issue_s;
        bus.src_rd_addr            = addr_r;
        bus.load_clause_out        = ret_valid_s && ret_tag_s.is_clause;
        bus.load_ptr_out           = ret_valid_s && !ret_tag_s.is_clause;
        bus.load_change_engine_out = ret_valid_s && ret_tag_s.first_of_engine &&
                                     (engine_r != EW'(0));
        if (ret_valid_s) begin
            bus.clause_out = bus.src_rd_data;
            bus.ptr_out    = bus.src_rd_data[DUMMY_W-1:0];
        end else begin
            bus.clause_out = '0;
            bus.ptr_out    = '0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_preload_streamer.sv
// Directed table-driven bench for preload_streamer with a loader model on the beat stream.
module tb_preload_streamer;
    import preload_streamer_pkg::*;

    localparam int NE  = 2;
    localparam int LIT = 2;
    localparam int MC  = 256;
    localparam int AW  = 16;
    localparam int CW  = $clog2(MC + 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic [NE*CW-1:0]  cla_count_in = '0;
    logic              busy;
    logic              done;

    preload_streamer_if #(.ADDR_W(AW)) bus ();

    preload_streamer #(
        .NUM_ENGINE (NE),
        .LIT_IDX_MAX(LIT),
        .MAX_CLA    (MC),
        .ADDR_W     (AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .cla_count_in(cla_count_in),
        .bus         (bus),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    function automatic node_t word_at(input logic [AW-1:0] a);
        return {a ^ 16'hC3C3, a};
    endfunction

    // Fixed one-cycle-latency source memory; garbage when not read.
    always @(posedge clock) begin
        bus.src_rd_data <= bus.src_rd_en ? word_at(bus.src_rd_addr) : 32'hDEAD_BEEF;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor and loader-model state.
    bit logging = 1'b0;
    int t0, beats, clause_n, first_cyc, done_cyc, done_n, change_n, change_addr;
    int exp_addr, eng_m, eng_max, cur_c0, cur_c1;
    int cla_rx [NE];
    int ptr_rx [NE];

    function automatic bit clause_at(input int a);
        int e0_end;
        e0_end = cur_c0 + 2*LIT;
        if (a < e0_end) return a < cur_c0;
        return (a - e0_end) < cur_c1;
    endfunction

    function automatic bit change_at(input int a);
        return a == cur_c0 + 2*LIT;
    endfunction

    always @(posedge clock) begin
        #1;
        if (logging) begin
            if (bus.load_clause_out || bus.load_ptr_out) begin
                chk("beat_addr", 32'(bus.ptr_out), 32'(exp_addr));
                chk("beat_word", bus.clause_out, word_at(AW'(exp_addr)));
                chk("beat_kind", {30'd0, bus.load_clause_out, bus.load_ptr_out},
                    {30'd0, clause_at(exp_addr), !clause_at(exp_addr)});
                chk("change_engine", 32'(bus.load_change_engine_out), 32'(change_at(exp_addr)));
                chk("busy_in_beat", 32'(busy), 32'd1);
                if (bus.load_change_engine_out) begin
                    eng_m++;
                    change_n++;
                    change_addr = exp_addr;
                end
                if (eng_m > eng_max) eng_max = eng_m;
                if (eng_m < NE) begin
                    if (bus.load_clause_out) cla_rx[eng_m]++;
                    else ptr_rx[eng_m]++;
                end
                if (first_cyc < 0) first_cyc = cyc - t0;
                beats++;
                exp_addr++;
            end else begin
                chk("idle_payload", bus.clause_out | 32'(bus.ptr_out) |
                    32'(bus.load_change_engine_out), 32'd0);
            end
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc - t0;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    typedef struct {
        int c0, c1;
        int pause_at, pause_len, restart_at;
        int exp_beats, exp_clause, exp_first, exp_done, exp_change_addr;
    } vec_t;

    vec_t vecs [6];

    task automatic clear_model(input int c0, input int c1);
        beats = 0; clause_n = 0; first_cyc = -1; done_cyc = -1; done_n = 0;
        change_n = 0; change_addr = -1; exp_addr = 0; eng_m = 0; eng_max = 0;
        cur_c0 = c0; cur_c1 = c1;
        for (int e = 0; e < NE; e++) begin
            cla_rx[e] = 0;
            ptr_rx[e] = 0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int r;
        clear_model(v.c0, v.c1);
        @(negedge clock);
        cla_count_in = {CW'(v.c1), CW'(v.c0)};
        start   = 1'b1;
        t0      = cyc;
        logging = 1'b1;
        for (int k = 0; k < 80 && done_cyc < 0; k++) begin
            @(negedge clock);
            r = cyc - t0;
            start = (v.restart_at != 0) && (r == v.restart_at);
            if (start) cla_count_in = '0;
            pause = (v.pause_len != 0) && (r >= v.pause_at) && (r < v.pause_at + v.pause_len);
        end
        start = 1'b0;
        pause = 1'b0;
        repeat (3) @(negedge clock);
        logging = 1'b0;
        clause_n = cla_rx[0] + cla_rx[1];
        chk("total_beats", 32'(beats), 32'(v.exp_beats));
        chk("clause_beats", 32'(clause_n), 32'(v.exp_clause));
        chk("first_beat_cycle", 32'(first_cyc), 32'(v.exp_first));
        chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
        chk("done_pulses", 32'(done_n), 32'd1);
        chk("change_count", 32'(change_n), 32'(NE - 1));
        chk("change_addr", 32'(change_addr), 32'(v.exp_change_addr));
        chk("eng0_clauses", 32'(cla_rx[0]), 32'(v.c0));
        chk("eng1_clauses", 32'(cla_rx[1]), 32'(v.c1));
        chk("eng0_ptrs", 32'(ptr_rx[0]), 32'(2*LIT));
        chk("eng1_ptrs", 32'(ptr_rx[1]), 32'(2*LIT));
        chk("engine_bound", 32'(eng_max), 32'(NE - 1));
    endtask

    initial begin
        //          c0 c1 pAt pLen rst beats cla first done chg
        vecs[0] = '{3, 2, 0, 0, 0, 13, 5, 2, 15, 7};
        vecs[1] = '{0, 0, 0, 0, 0,  8, 0, 2, 10, 4};
        vecs[2] = '{2, 1, 2, 3, 0, 11, 3, 2, 16, 6};
        vecs[3] = '{3, 2, 0, 0, 5, 13, 5, 2, 15, 7};
        vecs[4] = '{2, 1, 0, 0, 0, 11, 3, 2, 13, 6};
        vecs[5] = '{0, 3, 0, 0, 0, 11, 3, 2, 13, 4};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", {26'd0, bus.src_rd_en, bus.load_clause_out, bus.load_ptr_out,
            bus.load_change_engine_out, busy, done}, 32'd0);
        chk("reset_payload", bus.clause_out | 32'(bus.ptr_out), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Abort on reset at the 5th beat, then restart from address 0.
        clear_model(3, 2);
        @(negedge clock);
        cla_count_in = {CW'(2), CW'(3)};
        start   = 1'b1;
        t0      = cyc;
        logging = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 40 && beats < 5; k++) @(negedge clock);
        chk("reached_beat5", 32'(beats), 32'd5);
        reset   = 1'b1;
        logging = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            chk("reset_abort", {26'd0, bus.src_rd_en, bus.load_clause_out, bus.load_ptr_out,
                bus.load_change_engine_out, busy, done}, 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/preload_streamer.md
Name: preload_streamer

Overview:
- Transmit side of the preprocess load interface; drives the latency-buffered clause/pointer loader, one engine after another.
- On a start command it reads the preprocessed image from a fixed-latency source memory.
- It serialises the image as per-engine clause beats, then exactly 2*LIT_IDX_MAX pointer beats per engine.
- It inserts the change-engine strobe so the loader's engine and pointer-engine indicators advance in lockstep with the stream.

Parameters:
NUM_ENGINE, 4, engines loaded per image; also the width of the engine-index counter.
LIT_IDX_MAX, 16, literal index range; pointer beats per engine = 2*LIT_IDX_MAX.
MAX_CLA, 256, maximum clauses per engine.
ADDR_W, 16, source memory address width.

Ports:
clock  in  1  clock.
reset  in  1  synchronous, active-high.
start  in  1  begin streaming; sampled only in IDLE.
pause  in  1  while high, no new reads are issued; an in-flight read still completes.
cla_count_in  in  NUM_ENGINE*$clog2(MAX_CLA+1)  clauses per engine, engine 0 in the LSBs; latched on accepted start.
src_rd_en  out  1  source memory read strobe.
src_rd_addr  out  ADDR_W  source word address.
src_rd_data  in  node_t  read data, valid exactly 1 cycle after src_rd_en.
clause_out  out  node_t  clause beat payload.
ptr_out  out  dummy_entry_t  pointer beat payload; bit-slice of the same source word.
load_clause_out  out  1  clause beat strobe.
load_ptr_out  out  1  pointer beat strobe.
load_change_engine_out  out  1  advance the loader's engine indicator.
busy  out  1  streaming in progress.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, all counters and latched counts 0. A reset mid-stream aborts immediately; no further strobes follow.
- Memory layout is contiguous, addresses from 0, per engine e in order: cla_count[e] clause words, then 2*LIT_IDX_MAX pointer words. The address counter increments by 1 per issued read.
- FSM states: IDLE, CLA, PTR, DONE.
  - IDLE + start: latch counts, engine=0, addr=0, busy=1. Go to CLA, or to PTR if cla_count[0]==0.
  - CLA: one read per unpaused cycle. After cla_count[e] reads, go to PTR.
  - PTR: one read per unpaused cycle. After 2*LIT_IDX_MAX reads:
    - if e==NUM_ENGINE-1, go to DONE;
    - otherwise e++, then go to CLA, or to PTR directly when cla_count[e]==0.
  - DONE: busy=0, done=1 for one cycle, then IDLE.
- Beat tagging: each read carries a tag {is_clause, first_of_engine} in a 1-stage register. In the cycle src_rd_data returns:
  - load_clause_out or load_ptr_out = 1;
  - clause_out and ptr_out = src_rd_data slices;
  - load_change_engine_out = first_of_engine && engine>0.
- Change-engine placement: the strobe rides on the first beat of engines 1..N-1, whether that beat is a clause or a pointer. This is required because the loader applies the increment before routing a clause in the same cycle.
- Non-strobe cycles: clause_out and ptr_out are 0.
- Latency: first beat strobe appears 2 cycles after the cycle start is sampled. Throughput is 1 beat/cycle when unpaused. done asserts the cycle after the final pointer beat; busy falls with done.
- Pause: the read in flight at pause assertion is still delivered. Beats resume on the cycle after pause deasserts, with no duplicates and no skips.
- start while not IDLE: ignored.
- Total beats = sum(cla_count) + NUM_ENGINE*2*LIT_IDX_MAX.
- Counter widths:
  - clause counter: $clog2(MAX_CLA+1);
  - pointer counter: $clog2(2*LIT_IDX_MAX)+1;
  - the pointer counter must not wrap before reaching 2*LIT_IDX_MAX.

Decomposition:
- Shared package: node_t, dummy_entry_t, NUM_ENGINE, LIT_IDX_MAX, and a beat-tag struct {is_clause, first_of_engine}.
- Sub-module read_tag_pipe: 1-stage tag/valid register aligned to the memory latency. It is parameterisable to N stages for future memory changes.

Test Plan:
- NUM_ENGINE=2, LIT_IDX_MAX=2, counts {3,2}, start at cycle 0:
  - 13 beats on cycles 2–14 from addresses 0–12;
  - clause beats at addresses 0–2 and 7–8; pointer beats at 3–6 and 9–12;
  - change_engine only on the addr 7 beat;
  - done at cycle 15.
- Counts {0,0}: 8 pointer beats; change_engine on the addr 4 pointer beat; no clause strobes.
- Counts {2,1}, pause high for 3 cycles starting the cycle after the first read: exactly 11 beats, strictly ordered addresses, the one in-flight beat still delivered, done delayed by 3 cycles.
- start pulsed again while busy: ignored; the beat sequence is identical to the single-start run.
- Reset asserted at the 5th beat: all strobes 0 from the next cycle, busy=0. A new start then restarts from addr 0 with engine 0.
- Scoreboard with a loader model: per engine, the received clause count matches and exactly 2*LIT_IDX_MAX pointers arrive; the engine index never exceeds NUM_ENGINE-1.
